// File: rtl/bcd_conv_seq_if.sv
// Handshake bundle between divider and bcd_conv_seq.
// START/BIN/ERR_IN request; BUSY/DONE/BCD/ERR result.
interface bcd_conv_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  START;
  logic [WIDTH-1:0]      BIN;
  logic                  ERR_IN;
  logic                  BUSY;
  logic                  DONE;
  logic [4*DIGITS-1:0]   BCD;
  logic                  ERR;

  modport master (
    output START, BIN, ERR_IN,
    input  BUSY, DONE, BCD, ERR
  );

  modport slave (
    input  START, BIN, ERR_IN,
    output BUSY, DONE, BCD, ERR
  );
endinterface

// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD (double dabble), one bit/clk.
// clk, rst (async high); bus: START/BIN/ERR_IN in, BUSY/DONE/BCD/ERR out.
module bcd_conv_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic           clk,
  input  logic           rst,
  bcd_conv_seq_if.slave  bus
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_bin;
  logic [SW-1:0]    r_scr;
  logic [CW-1:0]    r_cnt;
  logic             r_err_lat;
  logic [SW-1:0]    r_bcd;
  logic             r_err;

  logic [SW-2:0]    w_adj;
  logic [3:0]       w_top;
  logic [SW-1:0]    w_scr_nxt;
  logic [WIDTH-1:0] w_bin_nxt;
  logic             w_last;

  // The top digit's MSB is shifted out, so only its
  // low three bits are kept (mod-8 add equals them).
  assign w_top = r_scr[SW-1 -: 4];

  always_comb begin
    logic [3:0] d;
    w_adj = '0;
    for (int i = 0; i < DIGITS - 1; i++) begin
      d = r_scr[4*i +: 4];
      w_adj[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    w_adj[SW-2 -: 3] = w_top[2:0] +
      ((w_top >= 4'd5) ? 3'd3 : 3'd0);
  end

  assign w_scr_nxt = {w_adj, r_bin[WIDTH-1]};
  assign w_bin_nxt = {r_bin[WIDTH-2:0], 1'b0};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_scr     <= '0;
      r_cnt     <= '0;
      r_err_lat <= 1'b0;
      r_bcd     <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_CONV: begin
          r_scr <= w_scr_nxt;
          r_bin <= w_bin_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_bcd   <= r_err_lat ? '1 : w_scr_nxt;
            r_err   <= r_err_lat;
          end
        end
        default: begin
          if (bus.START) begin
            r_state   <= S_CONV;
            r_bin     <= bus.BIN;
            r_scr     <= '0;
            r_cnt     <= '0;
            r_err_lat <= bus.ERR_IN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.BUSY = (r_state == S_CONV);
  assign bus.DONE = (r_state == S_DONE);
  assign bus.BCD  = r_bcd;
  assign bus.ERR  = r_err;
endmodule

// File: doc/bcd_conv_seq.md
Name: bcd_conv_seq

Overview:
- Multi-cycle binary-to-BCD converter (shift-add-3 / double dabble), directly downstream of the 16-bit divider.
- Consumes the divider's 16-bit quotient and produces packed BCD digits for the display/decoder stage.
- Includes an error flag path so a divide-by-zero upstream renders as a blank/error code instead of a number.
- Processes one bit per clock.

Parameters:
WIDTH, 16, binary input width; 16 matches the divider quotient.
DIGITS, 5, BCD output digits; 10^DIGITS must exceed 2^WIDTH-1 (5 for 16 bits).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
START  input  1  request conversion; sampled on the rising edge of clk
BIN  input  WIDTH  binary value (divider quotient), captured when START is accepted
ERR_IN  input  1  upstream error (divisor == 0), captured with BIN
BUSY  output  1  high while a conversion is in progress
DONE  output  1  one-cycle pulse: BCD/ERR valid and updated
BCD  output  4*DIGITS  packed BCD; digit 0 in [3:0]; registered, holds until next DONE
ERR  output  1  registered copy of the captured ERR_IN; updated with BCD

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset (async, any state): state=IDLE; BUSY=0; DONE=0; BCD=0; ERR=0; shift register and counter cleared. An in-flight conversion is discarded, and no DONE is produced for it.
- States: IDLE, CONVERT, DONE.
- START acceptance:
  - START is accepted in IDLE or DONE and ignored in CONVERT. There is no queuing.
  - On acceptance: BIN is loaded into the binary shift register, the BCD scratch register is cleared, ERR_IN is latched, bit counter=0, next state=CONVERT.
- CONVERT, one iteration per clock:
  - Every scratch digit >= 5 gets +3 (4-bit add, no carry between digits).
  - The combined {scratch, binary} register then shifts left 1.
  - Counter increments each iteration; after the WIDTH-th iteration, next state=DONE.
- Output register update on entry to DONE (same edge as the last shift):
  - ERR latched 0: BCD <= scratch.
  - ERR latched 1: BCD <= all ones (every digit 4'hF).
  - ERR <= latched ERR_IN.
- DONE state: lasts exactly one cycle with DONE=1, then returns to IDLE unless START is high, which starts a new conversion.
- Handshake outputs:
  - BUSY = 1 exactly in CONVERT; DONE = 1 exactly in DONE; never both.
- Latency: START sampled at edge E0 -> BUSY high E0..E(WIDTH) -> DONE high from E(WIDTH) to E(WIDTH+1). That is 16 cycles for WIDTH=16. Back-to-back throughput is WIDTH+1 cycles per result.
- BIN and ERR_IN changes after acceptance have no effect on the running conversion.
- BCD and ERR hold their values across IDLE and CONVERT; they change only on DONE entry or reset.
- Width rules: the scratch register is 4*DIGITS bits and the bit counter is $clog2(WIDTH+1) bits. The add-3 never overflows a digit because a digit is adjusted only when <= 9.
- The maximum input (2^WIDTH-1) must convert without truncation.

Test Plan:
- Reset then BIN=16'd0, START pulse -> BUSY high 16 cycles; DONE pulse at E16; BCD=20'h00000, ERR=0.
- BIN=16'd65535 (divider output for B=0 without flag), ERR_IN=0 -> BCD=20'h65535. BIN=16'd1234 -> BCD=20'h01234. BIN=16'd142 (1000/7) -> BCD=20'h00142.
- ERR_IN=1 with BIN=16'hFFFF -> BCD=20'hFFFFF, ERR=1. A following conversion of 16'd9 with ERR_IN=0 -> BCD=20'h00009, ERR=0.
- START held high during CONVERT with BIN changing every cycle -> ignored. Result equals the value captured at E0, and exactly one DONE occurs.
- START high during the DONE cycle with BIN=16'd500 -> new conversion starts with no IDLE gap; second DONE arrives 17 cycles after the first, BCD=20'h00500.
- rst asserted asynchronously mid-CONVERT (cycle 7) -> BUSY, DONE, BCD and ERR go to 0 immediately, with no DONE afterwards. A new START converts 16'd42 -> BCD=20'h00042.
